line_memory_responder: RTL
==========================

Name: line_memory_responder

Overview:
- Backing-store responder for the cache's line-fill and write-back interface.
- Accepts one whole-line read or write request at a time from the cache initiator.
- Models a fixed access latency, then returns read data with a one-cycle valid pulse.
- Sits below the cache; the cache drives the request side, this block drives mem_ready, is_output_valid and dout.

Parameters:
- BLOCK_SIZE, 16, line size in bytes; the data bus is BLOCK_SIZE*8 bits wide.
- NUM_LINES, 16384, number of lines stored; must be a power of two.
- DELAY, 50, access latency in cycles; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- is_input_valid  input  1  a request is present this cycle.
- addr  input  32  line index; the initiator has already shifted it right by CLOG2(BLOCK_SIZE).
- mem_read  input  1  request is a line read.
- mem_write  input  1  request is a line write.
- din  input  BLOCK_SIZE*8  write-line data.
- is_output_valid  output  1  dout holds read data this cycle; one-cycle pulse.
- dout  output  BLOCK_SIZE*8  read-line data.
- mem_ready  output  1  the block can accept a request this cycle.
- req_error  output  1  one-cycle pulse when a malformed request is rejected.

Behaviour:
- Reset (asynchronous, reset=0):
  - state goes to IDLE; latency counter, latched address, latched data and latched op go to 0.
  - Outputs while reset is held: mem_ready=0, is_output_valid=0, dout=0, req_error=0.
  - mem_ready=1 from the first cycle after reset is released.
  - Array contents are not cleared by reset. The array initialises to all-zero at time 0.
  - Reset asserted mid-operation aborts the request. A pending write is not committed.
- Index mapping: line = addr[CLOG2(NUM_LINES)-1:0]. Upper address bits are ignored, so addresses wrap.
- States:
  - IDLE: mem_ready=1.
  - BUSY: latency countdown; mem_ready=0.
  - RESPOND: read completion only; mem_ready=0, is_output_valid=1.
- Accept: a request is accepted at rising edge k when state is IDLE and is_input_valid=1 and exactly one of mem_read or mem_write is 1.
  - On accept, latch addr, din and op; load counter with DELAY-1; go to BUSY.
- Reject:
  - is_input_valid=1 in IDLE with mem_read=mem_write (both 1 or both 0) is rejected.
  - req_error pulses for the cycle after edge k. State stays IDLE and nothing is latched.
- Requests while busy: is_input_valid while mem_ready=0 is ignored.
  - The initiator must hold the request until it sees mem_ready=1.
  - A request sampled in the same edge that returns the block to IDLE is not accepted; it is accepted at the next edge.
- BUSY: counter decrements by 1 each edge. When counter=0 at an edge (edge k+DELAY):
  - Write: array[line] is written with the latched din; next state is IDLE. No is_output_valid pulse is produced for a write.
  - Read: dout is loaded with array[line]; next state is RESPOND.
- RESPOND: lasts exactly one cycle (the cycle after edge k+DELAY), then IDLE.
  - mem_ready=1 from the cycle after edge k+DELAY+1.
- Ready timing relative to accept edge k:
  - Write: mem_ready is low for exactly DELAY cycles.
  - Read: mem_ready is low for exactly DELAY+1 cycles.
- dout is 0 whenever is_output_valid=0.
- Read-after-write to the same line returns the newly written data. The write commits before the block is ready again.
- Latched address and data are used for the whole operation. Changes on addr, din or op after accept have no effect.

Test Plan:
- Reset release, then a read of line 5 with a zero array, DELAY=50 -> mem_ready low for 51 cycles; is_output_valid high exactly 51 cycles after the accept edge; dout=0.
- Write line 5 with 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, then read line 5 -> the write shows no is_output_valid and ready returns after 50 cycles; the read returns that exact value.
- Write line 3, then read addr=3+NUM_LINES -> the read returns the line-3 data (index wrap).
- Request with mem_read=1 and mem_write=1 in IDLE -> req_error pulses for one cycle; mem_ready stays 1; a following read of the same line returns the old data.
- Change addr and din every cycle during BUSY after a write accept -> only the originally latched line and data are stored.
- Assert reset at cycle 20 of a pending write to line 7, release, then read line 7 -> outputs go 0 immediately on reset; line 7 keeps its previous content.

Source files
------------

// File: rtl/line_memory_responder.sv
// Whole-line backing store below the cache: accepts one read or write at a
// time, models a fixed access latency and pulses read data back for one cycle.
module line_memory_responder #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_LINES  = 16384,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready,
  output logic                    req_error
);

  localparam int DATA_W = BLOCK_SIZE * 8;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int CNT_W  = $clog2(DELAY + 1);

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);
  localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [IDX_W-1:0]  line_r;
  logic [DATA_W-1:0] data_r;
  logic              op_write_r;

  logic              accept_s;
  logic              reject_s;
  logic              commit_s;

  logic              ready_nxt_s;
  logic              valid_nxt_s;
  logic              err_nxt_s;
  logic [DATA_W-1:0] dout_nxt_s;

  logic              ready_r;
  logic              valid_r;
  logic              err_r;
  logic [DATA_W-1:0] dout_r;

  logic [DATA_W-1:0] mem_r [NUM_LINES];

  // Upper address bits are deliberately dropped so line indices wrap.
  logic              unused_addr_s;
  assign unused_addr_s = ^addr[31:IDX_W];

  assign commit_s = (state_r == ST_BUSY) && (cnt_r == CNT_ZERO) && op_write_r;

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= CNT_ZERO;
      line_r     <= IDX_ZERO;
      data_r     <= DATA_ZERO;
      op_write_r <= 1'b0;
      ready_r    <= 1'b0;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      dout_r     <= DATA_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        line_r     <= addr[IDX_W-1:0];
        data_r     <= din;
        op_write_r <= mem_write;
      end
      ready_r <= ready_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
      dout_r  <= dout_nxt_s;
    end
  end

  // Next-state logic: accept/reject in IDLE, latency countdown in BUSY.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // ready_r is low for the first cycle after reset, so nothing is taken then.
        if (ready_r && is_input_valid) begin
          if (mem_read ^ mem_write) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = CNT_LOAD;
          end else begin
            reject_s    = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_ZERO) begin
          if (op_write_r) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RESPOND;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      ST_RESPOND: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode from the upcoming state; dout is only non-zero in RESPOND.
  always_comb begin
    ready_nxt_s = (state_nxt_s == ST_IDLE);
    valid_nxt_s = (state_nxt_s == ST_RESPOND);
    err_nxt_s   = reject_s;
    if (state_nxt_s == ST_RESPOND) begin
      dout_nxt_s = mem_r[line_r];
    end else begin
      dout_nxt_s = DATA_ZERO;
    end
  end

  // Line array; not reset, and a write lands only on the final countdown edge.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[line_r] <= data_r;
    end
  end

  assign mem_ready       = ready_r;
  assign is_output_valid = valid_r;
  assign req_error       = err_r;
  assign dout            = dout_r;

endmodule
